// File: rtl/rca_seq_ctrl.sv
// Sequencer that runs a wide add through one shared 4-bit ripple-carry adder,
// one nibble per clock, LSB first, chaining the slice carry through a register.
module rca_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic [3:0]             rca_a,
  output logic [3:0]             rca_b,
  output logic                   rca_c,
  input  logic [3:0]             rca_y,
  input  logic                   rca_cout
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    rca_a_q, rca_a_d;
  logic [3:0]    rca_b_q, rca_b_d;
  logic          rca_c_q, rca_c_d;

  logic [IW-1:0] idx_nxt;
  logic          idx_last;

  assign idx_nxt  = idx_q + IW'(1);
  assign idx_last = (idx_q == IW'(NIBBLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rca_a_q <= 4'd0;
      rca_b_q <= 4'd0;
      rca_c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rca_a_q <= rca_a_d;
      rca_b_q <= rca_b_d;
      rca_c_q <= rca_c_d;
    end
  end

  // The rca drive registers are loaded with the slice the next cycle will use,
  // so the adder sees only flop outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rca_a_d = 4'd0;
    rca_b_d = 4'd0;
    rca_c_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          carry_d = cin;
          idx_d   = '0;
          state_d = S_RUN;
          busy_d  = 1'b1;
          rca_a_d = a_in[3:0];
          rca_b_d = b_in[3:0];
          rca_c_d = cin;
        end
      end
      S_RUN: begin
        sum_d[4*idx_q +: 4] = rca_y;
        carry_d             = rca_cout;
        busy_d              = 1'b1;
        if (idx_last) begin
          cout_d  = rca_cout;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_nxt;
          rca_a_d = a_q[4*idx_nxt +: 4];
          rca_b_d = b_q[4*idx_nxt +: 4];
          rca_c_d = rca_cout;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign rca_a = rca_a_q;
  assign rca_b = rca_b_q;
  assign rca_c = rca_c_q;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed and random checks of rca_seq_ctrl driving a behavioural 4-bit rca,
// with expected results queued at stimulus time and popped on each done.
module tb_rca_seq_ctrl;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = 4 * NIBBLES;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [3:0]   rca_a;
  logic [3:0]   rca_b;
  logic         rca_c;
  logic [3:0]   rca_y;
  logic         rca_cout;

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];

  rca_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .reset(reset), .start(start),
    .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .rca_a(rca_a), .rca_b(rca_b), .rca_c(rca_c),
    .rca_y(rca_y), .rca_cout(rca_cout)
  );

  // Shared 4-bit ripple-carry adder slice
  assign {rca_cout, rca_y} = 5'(rca_a) + 5'(rca_b) + 5'(rca_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    a_in  = a;
    b_in  = b;
    cin   = c;
    start = 1'b1;
    exp_q.push_back((W+1)'(a) + (W+1)'(b) + (W+1)'(c));
    @(posedge clk);
    #1;
    start = 1'b0;
    a_in  = ~a;
    b_in  = ~b;
    cin   = ~c;
  endtask

  // Waits for done, checks latency, result and one-cycle pulse; ends at a negedge.
  task automatic wait_done(input string tag, output logic [3:0] cmask);
    int lat;
    logic [W:0] expv;
    lat   = -1;
    cmask = 4'd0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i < 4) cmask[i] = rca_c;
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    if (lat >= 0) begin
      if (exp_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        expv = exp_q.pop_front();
        check({tag, "_result"}, 32'({cout, sum}), 32'(expv));
      end
      @(negedge clk);
      check({tag, "_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] cm;
    logic [W-1:0] ra, rb;
    logic rc;
    logic done_seen;

    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'({cout, sum}), 32'd0);
    check("rst_rca",  32'({rca_a, rca_b, rca_c}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic add with latency check
    start_op(16'h1234, 16'h4321, 1'b0);
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", cm);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_rca", 32'({rca_a, rca_b, rca_c}), 32'd0);

    // 2: carry ripples across all slices
    start_op(16'hFFFF, 16'h0000, 1'b1);
    wait_done("t2", cm);
    check("t2_rca_c", 32'(cm), 32'hF);

    // 3: max operands with carry-in
    start_op(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done("t3", cm);

    // 4: start held high, operands change while busy
    a_in  = 16'h0001;
    b_in  = 16'h0001;
    cin   = 1'b0;
    start = 1'b1;
    exp_q.push_back(17'h00002);
    @(posedge clk);
    #1;
    a_in = 16'hAAAA;
    b_in = 16'hAAAA;
    wait_done("t4a", cm);
    check("t4_idle_busy", 32'(busy), 32'd0);
    exp_q.push_back(17'h15554);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("t4_accept_busy", 32'(busy), 32'd1);
    wait_done("t4b", cm);

    // 5: async reset in the second RUN cycle
    start_op(16'h0003, 16'h0005, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_sum",  32'({cout, sum}), 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    check("t5_no_done", 32'(done_seen), 32'd0);
    start_op(16'h00FF, 16'h0001, 1'b0);
    wait_done("t5_after", cm);

    // 6: random back-to-back ops
    for (int n = 0; n < 180; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      start_op(ra, rb, rc);
      wait_done("rnd", cm);
    end
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
